reg_pipe: RTL and testbench

Parametrised register pipeline with a valid/ready handshake on both sides. It holds WIDTH-bit data in DEPTH register stages. Empty stages collapse, so the pipeline absorbs backpressure: when the output stalls it accepts up to DEPTH words. Unlike a plain D flip-flop it adds width and depth generalisation, per-stage valid tracking, stall/flow control, a synchronous flush and an occupancy count. It sits between any producer and consumer that need a fixed-latency, stallable retiming stage.

---
 rtl/reg_pipe.sv | 66 ++++++
 tb/tb_reg_pipe.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_pipe.sv
// reg_pipe: stallable WIDTH x DEPTH register pipeline with valid/ready on both
// sides. Empty stages collapse, so it buffers up to DEPTH words under
// backpressure. Synchronous flush and a combinational occupancy count.
module reg_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    occupancy
);

    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0][WIDTH-1:0] data;
    logic [DEPTH-1:0]            rdy;

    // Stage g may load when the consumer takes a word or any stage from g
    // onward is empty; this is the unrolled ready chain, free of bit-level loops.
    for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
        assign rdy[g] = out_ready | ~(&valid[DEPTH-1:g]);
    end

    assign in_ready  = rdy[0] & ~clr;
    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];

    // Stage registers: shift forward wherever the downstream side can accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            data  <= {DEPTH{RST_VAL}};
        end else if (clr) begin
            valid <= '0;
            data  <= {DEPTH{RST_VAL}};
        end else begin
            if (rdy[0]) begin
                valid[0] <= in_valid;
                data[0]  <= in_data;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (rdy[i]) begin
                    valid[i] <= valid[i-1];
                    data[i]  <= data[i-1];
                end
            end
        end
    end

    // Occupancy: popcount of the stage valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occupancy = occupancy + CW'(valid[i]);
        end
    end

endmodule

// File: tb/tb_reg_pipe.sv
// Bench for reg_pipe (WIDTH=8, DEPTH=4). The reference model is a queue of
// words with their stage positions; each edge it pops the word leaving, moves
// words forward into free space and appends any accepted input.
module tb_reg_pipe;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       occupancy;

    int checks   = 0;
    int failures = 0;

    int         mpos[$];
    logic [7:0] mdat[$];

    reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    function automatic bit m_ov();
        return (mpos.size() > 0) && (mpos[0] == int'(DEPTH) - 1);
    endfunction

    function automatic int m_occ();
        return mpos.size();
    endfunction

    function automatic bit m_ird();
        return !clr && (out_ready || mpos.size() < int'(DEPTH));
    endfunction

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic tick();
        bit ir;
        bit ox;
        @(posedge clk);
        ir = m_ird();
        ox = m_ov() && out_ready;
        if (!rst) begin
            mpos.delete();
            mdat.delete();
        end else begin
            if (ox) begin
                void'(mpos.pop_front());
                void'(mdat.pop_front());
            end
            if (clr) begin
                mpos.delete();
                mdat.delete();
            end else begin
                for (int k = 0; k < mpos.size(); k++) begin
                    // k older words sit ahead; move if a free stage remains ahead
                    if (out_ready || k < int'(DEPTH) - 1 - mpos[k]) mpos[k] = mpos[k] + 1;
                end
                if (in_valid && ir) begin
                    mpos.push_back(0);
                    mdat.push_back(in_data);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] w;
        rst = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b0;
        repeat (3) tick();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom);
            in_valid = 1'b1; in_data = w;
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd3) begin failures++; $display("FAIL reset_preload_occ got=%0d exp=3", occupancy); end
        #2;
        rst = 1'b0;
        mpos.delete(); mdat.delete();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL async_rst_out_data got=%h exp=00", out_data); end
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL async_rst_occ got=%0d exp=0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL async_rst_in_ready got=%b exp=1", in_ready); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 8);
            in_data  = 8'(c + 1);
            #1;
            checks++;
            if (out_valid !== ((c >= 4 && c <= 11) ? 1'b1 : 1'b0)) begin
                failures++; $display("FAIL stream_out_valid cyc=%0d got=%b", c, out_valid);
            end
            if (c >= 4 && c <= 11) begin
                checks++;
                if (out_data !== 8'(c - 3)) begin
                    failures++; $display("FAIL stream_out_data cyc=%0d got=%h exp=%h", c, out_data, 8'(c - 3));
                end
            end
            checks++;
            if (occupancy !== 3'(m_occ()) || in_ready !== 1'b1) begin
                failures++; $display("FAIL stream_occ_ready cyc=%0d occ=%0d exp=%0d in_ready=%b", c, occupancy, m_occ(), in_ready);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] seq [6];
        int idx = 0;
        bit acc;
        for (int i = 0; i < 6; i++) seq[i] = 8'(8'h10 + i);
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_data = seq[idx];
            #1;
            checks++;
            if (in_ready !== ((c < 4) ? 1'b1 : 1'b0)) begin
                failures++; $display("FAIL bp_in_ready cyc=%0d got=%b", c, in_ready);
            end
            acc = m_ird();
            tick();
            if (acc) idx++;
        end
        #1;
        checks++; if (idx != 4) begin failures++; $display("FAIL bp_accepted got=%0d exp=4", idx); end
        checks++; if (occupancy !== 3'd4) begin failures++; $display("FAIL bp_full_occ got=%0d exp=4", occupancy); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h10) begin
            failures++; $display("FAIL bp_full_head valid=%b data=%h exp=1/10", out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            in_valid = (idx < 6);
            in_data  = seq[(idx < 6) ? idx : 5];
            #1;
            if (c < 6) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 8'(8'h10 + c)) begin
                    failures++; $display("FAIL bp_drain cyc=%0d valid=%b data=%h exp=%h", c, out_valid, out_data, 8'(8'h10 + c));
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained cyc=%0d valid=%b exp=0", c, out_valid); end
            end
            acc = m_ird() && in_valid;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full_simul();
        logic [7:0] sb[$];
        logic [7:0] w;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 8'($urandom); in_valid = 1'b1; in_data = w; sb.push_back(w);
            tick();
        end
        out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            in_valid = (c < 5);
            w = 8'($urandom); in_data = w;
            #1;
            if (c < 5) begin
                checks++;
                if (occupancy !== 3'd4 || in_ready !== 1'b1) begin
                    failures++; $display("FAIL full_simul_occ cyc=%0d occ=%0d in_ready=%b exp=4/1", c, occupancy, in_ready);
                end
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== sb[0]) begin
                failures++; $display("FAIL full_simul_order cyc=%0d valid=%b data=%h exp=%h", c, out_valid, out_data, sb[0]);
            end
            if (in_valid) sb.push_back(w);
            void'(sb.pop_front());
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin
            failures++; $display("FAIL full_simul_empty valid=%b occ=%0d exp=0/0", out_valid, occupancy);
        end
        @(negedge clk);
    endtask

    task automatic test_bubble();
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c == 0 || c == 2);
            in_data  = (c == 0) ? 8'hA0 : 8'hA1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd2) begin failures++; $display("FAIL bubble_occ got=%0d exp=2", occupancy); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA0) begin
            failures++; $display("FAIL bubble_head valid=%b data=%h exp=1/A0", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hA1) begin
            failures++; $display("FAIL bubble_second valid=%b data=%h exp=1/A1", out_valid, out_data);
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            tick();
        end
        clr = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
        tick();
        clr = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
            failures++; $display("FAIL flush_empty occ=%0d valid=%b exp=0/0", occupancy, out_valid);
        end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL flush_out_data got=%h exp=00", out_data); end
        tick();
        #1;
        checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL flush_not_taken occ=%0d exp=0", occupancy); end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            clr       = ($urandom % 40) == 0;
            in_data   = 8'($urandom);
            #1;
            checks++;
            if (out_valid !== m_ov() || occupancy !== 3'(m_occ()) || in_ready !== m_ird()) begin
                failures++;
                $display("FAIL random_ctrl cyc=%0d valid=%b/%b occ=%0d/%0d in_ready=%b/%b", c, out_valid, m_ov(), occupancy, m_occ(), in_ready, m_ird());
            end
            if (m_ov()) begin
                checks++;
                if (out_data !== mdat[0]) begin
                    failures++; $display("FAIL random_data cyc=%0d got=%h exp=%h", c, out_data, mdat[0]);
                end
            end
            tick();
        end
        clr = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_full_simul();
        test_bubble();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
